i2s_rx_stereo_in: RTL and testbench

- Upstream audio source for the stereo FM multiplexer.
- Receives a standard I2S serial stream (external slave: bclk, lrclk and sdata are driven off-chip).
- Deserializes each stereo frame and rounds each channel from 24-bit serial words to 18-bit signed samples.
- Presents the L/R pair on 18-bit registered outputs, updated only on the 48 kHz clock enable, so the multiplexer's LEFTin/RIGHTin are stable for a whole sample period.

---
 rtl/i2s_rx_stereo_in.sv | 233 +++++++++++++++++++++++
 tb/tb_i2s_rx_stereo_in.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_stereo_in.sv
// I2S slave receiver: deserializes L/R words, rounds and saturates them to OUT_BITS,
// and hands the pair to the multiplexer on the 48 kHz enable.
module i2s_rx_stereo_in #(
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 24,
  parameter int OUT_BITS  = 18
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       bclk_in,
  input  logic                       lrclk_in,
  input  logic                       sdata_in,
  input  logic                       clken48kHz,
  output logic signed [OUT_BITS-1:0] left_out,
  output logic signed [OUT_BITS-1:0] right_out,
  output logic                       frame_valid,
  output logic                       overrun,
  output logic                       sync_ok
);

  localparam int CNT_W   = $clog2(SLOT_BITS + 1);
  localparam int SHIFT_R = DATA_BITS - OUT_BITS;
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [DATA_BITS:0]  HALF_LSB = (DATA_BITS + 1)'(1) << (SHIFT_R - 1);
  localparam logic [OUT_BITS-1:0] MAX_POS  = {1'b0, {(OUT_BITS - 1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    WAIT
  } state_t;

  state_t state, state_n;

  logic [2:0] bclk_s;
  logic [1:0] lr_s;
  logic [1:0] sd_s;
  logic       lr_prev;
  logic       bclk_rise;
  logic       lr_now;
  logic       sd_now;
  logic       lr_edge;

  logic                 chan;
  logic [CNT_W-1:0]     bitcnt;
  logic [DATA_BITS-2:0] shreg;
  logic [DATA_BITS-1:0] word_in;
  logic [DATA_BITS-1:0] left_hold;
  logic [DATA_BITS-1:0] right_hold;
  logic                 left_valid;
  logic                 fdone;
  logic [1:0]           lock_cnt;

  logic shift_en;
  logic last_bit;
  logic short_slot;
  logic start_slot;

  logic [DATA_BITS:0]  left_sum;
  logic [DATA_BITS:0]  right_sum;
  logic [OUT_BITS-1:0] left_rnd;
  logic [OUT_BITS-1:0] right_rnd;
  logic [OUT_BITS-1:0] pend_l;
  logic [OUT_BITS-1:0] pend_r;
  logic                pending;
  logic                unused_sum;

  // Two-flop synchronizers; bclk gets a third flop so its rising edge becomes a one-cycle strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bclk_s <= '0;
      lr_s   <= '0;
      sd_s   <= '0;
    end else begin
      bclk_s <= {bclk_s[1:0], bclk_in};
      lr_s   <= {lr_s[0], lrclk_in};
      sd_s   <= {sd_s[0], sdata_in};
    end
  end

  assign bclk_rise = bclk_s[1] & ~bclk_s[2];
  assign lr_now    = lr_s[1];
  assign sd_now    = sd_s[1];
  assign lr_edge   = bclk_rise & (lr_now ^ lr_prev);
  assign word_in   = {shreg, sd_now};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // The bclk rise that reveals an lrclk edge is itself the I2S delay bit, so SKIP
  // only needs one clock to arm the counter before the MSB arrives
  always_comb begin
    state_n    = state;
    shift_en   = 1'b0;
    last_bit   = 1'b0;
    short_slot = 1'b0;
    start_slot = 1'b0;
    case (state)
      IDLE: begin
        if (lr_edge && !lr_now) begin
          start_slot = 1'b1;
          state_n    = SKIP;
        end
      end
      SKIP: begin
        state_n = SHIFT;
      end
      SHIFT: begin
        if (bclk_rise) begin
          if (bitcnt == LAST_BIT) begin
            shift_en = 1'b1;
            last_bit = 1'b1;
            if (lr_edge) begin
              start_slot = 1'b1;
              state_n    = SKIP;
            end else begin
              state_n = WAIT;
            end
          end else if (lr_edge) begin
            short_slot = 1'b1;
            start_slot = 1'b1;
            state_n    = SKIP;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      WAIT: begin
        if (lr_edge) begin
          start_slot = 1'b1;
          state_n    = SKIP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Word capture and channel sequencing; a right word only forms a frame behind a valid left word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lr_prev    <= 1'b0;
      chan       <= 1'b0;
      bitcnt     <= '0;
      shreg      <= '0;
      left_hold  <= '0;
      right_hold <= '0;
      left_valid <= 1'b0;
      fdone      <= 1'b0;
      lock_cnt   <= '0;
      sync_ok    <= 1'b0;
    end else begin
      fdone <= 1'b0;
      if (bclk_rise) begin
        lr_prev <= lr_now;
      end
      if (shift_en) begin
        shreg  <= word_in[DATA_BITS-2:0];
        bitcnt <= bitcnt + 1'b1;
      end
      if (last_bit) begin
        if (!chan) begin
          left_hold  <= word_in;
          left_valid <= 1'b1;
        end else if (left_valid) begin
          right_hold <= word_in;
          left_valid <= 1'b0;
          fdone      <= 1'b1;
          if (lock_cnt != 2'd2) begin
            lock_cnt <= lock_cnt + 1'b1;
          end
          if (lock_cnt != 2'd0) begin
            sync_ok <= 1'b1;
          end
        end
      end
      if (short_slot) begin
        left_valid <= 1'b0;
        lock_cnt   <= '0;
        sync_ok    <= 1'b0;
      end
      if (start_slot) begin
        chan   <= lr_now;
        bitcnt <= '0;
      end
    end
  end

  // Round half up at the output LSB; only positive words can carry into the sign bit
  assign left_sum   = {left_hold[DATA_BITS-1], left_hold} + HALF_LSB;
  assign right_sum  = {right_hold[DATA_BITS-1], right_hold} + HALF_LSB;
  assign left_rnd   = (!left_hold[DATA_BITS-1] && left_sum[DATA_BITS-1]) ?
                      MAX_POS : left_sum[DATA_BITS-1 -: OUT_BITS];
  assign right_rnd  = (!right_hold[DATA_BITS-1] && right_sum[DATA_BITS-1]) ?
                      MAX_POS : right_sum[DATA_BITS-1 -: OUT_BITS];
  assign unused_sum = ^{left_sum[DATA_BITS], left_sum[SHIFT_R-1:0],
                        right_sum[DATA_BITS], right_sum[SHIFT_R-1:0]};

  // Pending buffer decouples frame arrival from the sample enable; outputs move only on clken48kHz
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_l      <= '0;
      pend_r      <= '0;
      pending     <= 1'b0;
      left_out    <= '0;
      right_out   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_valid <= fdone;
      if (clken48kHz && pending) begin
        left_out  <= pend_l;
        right_out <= pend_r;
      end
      if (fdone) begin
        pend_l  <= left_rnd;
        pend_r  <= right_rnd;
        pending <= 1'b1;
        if (pending && !clken48kHz) begin
          overrun <= 1'b1;
        end
      end else if (clken48kHz) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_stereo_in.sv
// Scoreboard bench for i2s_rx_stereo_in: directed I2S frames, expected pairs queued
// per clken48kHz pulse and checked by an independent monitor.
module tb_i2s_rx_stereo_in;

  localparam int SLOT = 32;
  localparam int DB   = 24;
  localparam int OB   = 18;

  typedef struct packed {
    logic [OB-1:0] l;
    logic [OB-1:0] r;
  } pair_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          bclk_in = 1'b1;
  logic          lrclk_in = 1'b1;
  logic          sdata_in = 1'b0;
  logic          clken48kHz = 1'b0;
  logic [OB-1:0] left_out;
  logic [OB-1:0] right_out;
  logic          frame_valid;
  logic          overrun;
  logic          sync_ok;

  int    checks = 0;
  int    failures = 0;
  int    fv_count = 0;
  pair_t expq[$];
  event  lsb_ev;

  i2s_rx_stereo_in #(
    .SLOT_BITS(SLOT),
    .DATA_BITS(DB),
    .OUT_BITS (OB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bclk_in    (bclk_in),
    .lrclk_in   (lrclk_in),
    .sdata_in   (sdata_in),
    .clken48kHz (clken48kHz),
    .left_out   (left_out),
    .right_out  (right_out),
    .frame_valid(frame_valid),
    .overrun    (overrun),
    .sync_ok    (sync_ok)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bclk period: data and lrclk change on the falling edge, as an I2S master does
  task automatic drive_bit(input logic lr, input logic d, input logic mark);
    bclk_in  = 1'b0;
    lrclk_in = lr;
    sdata_in = d;
    #40;
    bclk_in = 1'b1;
    if (mark) ->lsb_ev;
    #40;
  endtask

  task automatic send_slot(input logic lr, input logic [DB-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(lr, (i >= 1 && i <= DB) ? w[DB-i] : 1'b0, lr && (i == DB));
    end
  endtask

  task automatic applyStimulus(input logic [DB-1:0] l, input logic [DB-1:0] r);
    @(negedge clock);
    #2;
    send_slot(1'b0, l, SLOT);
    send_slot(1'b1, r, SLOT);
    repeat (5) @(negedge clock);
  endtask

  task automatic pulse_clken(input logic [OB-1:0] l, input logic [OB-1:0] r);
    pair_t e;
    e.l = l;
    e.r = r;
    expq.push_back(e);
    @(negedge clock) clken48kHz = 1'b1;
    @(negedge clock) clken48kHz = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  // Monitor: every sampled clken48kHz is an output event, checked against the queued pair
  initial begin
    pair_t e;
    forever begin
      @(posedge clock);
      if (reset && clken48kHz) begin
        @(negedge clock);
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output: got L=0x%0h R=0x%0h expected none queued", left_out, right_out);
        end else begin
          e = expq.pop_front();
          checkOutput("left_out", 32'(left_out), 32'(e.l));
          checkOutput("right_out", 32'(right_out), 32'(e.r));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (frame_valid) fv_count++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (4) @(negedge clock);
    checkOutput("reset_left", 32'(left_out), 32'h0);
    checkOutput("reset_right", 32'(right_out), 32'h0);
    checkOutput("reset_fv", 32'(frame_valid), 32'h0);
    checkOutput("reset_overrun", 32'(overrun), 32'h0);
    checkOutput("reset_sync", 32'(sync_ok), 32'h0);
    reset = 1'b1;
    @(negedge clock);
    #2;
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, 1'b0);

    // Nominal frame; outputs must wait for the enable
    applyStimulus(24'h123456, 24'hFEDCBA);
    checkOutput("fv_count_nominal", 32'(fv_count), 32'd1);
    checkOutput("hold_left_before_clken", 32'(left_out), 32'h0);
    checkOutput("hold_right_before_clken", 32'(right_out), 32'h0);
    checkOutput("sync_after_one_frame", 32'(sync_ok), 32'h0);
    pulse_clken(18'h048D1, 18'h3FB73);

    // Saturation and rounding boundaries
    applyStimulus(24'h7FFFF0, 24'h800000);
    checkOutput("sync_after_two_frames", 32'(sync_ok), 32'h1);
    pulse_clken(18'h1FFFF, 18'h20000);
    applyStimulus(24'h00001F, 24'h000020);
    pulse_clken(18'h00000, 18'h00001);
    pulse_clken(18'h00000, 18'h00001);
    checkOutput("fv_count_three", 32'(fv_count), 32'd3);
    checkOutput("no_overrun_yet", 32'(overrun), 32'h0);

    // Short left slot, then an orphan right word
    @(negedge clock);
    #2;
    send_slot(1'b0, 24'hABCDEF, 11);
    send_slot(1'b1, 24'h111111, SLOT);
    repeat (5) @(negedge clock);
    checkOutput("sync_after_short", 32'(sync_ok), 32'h0);
    checkOutput("fv_count_short", 32'(fv_count), 32'd3);
    pulse_clken(18'h00000, 18'h00001);
    applyStimulus(24'h000040, 24'hFFFFC0);
    checkOutput("sync_relock_one", 32'(sync_ok), 32'h0);
    pulse_clken(18'h00001, 18'h3FFFF);
    applyStimulus(24'h400000, 24'hC00000);
    checkOutput("sync_relock_two", 32'(sync_ok), 32'h1);
    pulse_clken(18'h10000, 18'h30000);

    // Frame completion coincides with clken while a pair is pending
    applyStimulus(24'h000800, 24'h000900);
    fork
      applyStimulus(24'h000A00, 24'h000B00);
      begin
        pair_t e;
        @(lsb_ev);
        e.l = 18'h00020;
        e.r = 18'h00024;
        expq.push_back(e);
        repeat (3) @(posedge clock);
        @(negedge clock) clken48kHz = 1'b1;
        @(negedge clock) clken48kHz = 1'b0;
      end
    join
    checkOutput("overrun_simultaneous", 32'(overrun), 32'h0);
    checkOutput("fv_count_simul", 32'(fv_count), 32'd7);
    pulse_clken(18'h00028, 18'h0002C);

    // Three frames without an enable
    applyStimulus(24'h000100, 24'h000200);
    checkOutput("overrun_first", 32'(overrun), 32'h0);
    applyStimulus(24'h000300, 24'h000400);
    checkOutput("overrun_second", 32'(overrun), 32'h1);
    applyStimulus(24'h000500, 24'h000600);
    checkOutput("fv_count_overrun", 32'(fv_count), 32'd10);
    pulse_clken(18'h00014, 18'h00018);
    checkOutput("overrun_sticky", 32'(overrun), 32'h1);

    // Asynchronous reset in the middle of a right word
    @(negedge clock);
    #2;
    send_slot(1'b0, 24'h654321, SLOT);
    send_slot(1'b1, 24'h123123, 12);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("async_left", 32'(left_out), 32'h0);
    checkOutput("async_right", 32'(right_out), 32'h0);
    checkOutput("async_overrun", 32'(overrun), 32'h0);
    checkOutput("async_sync", 32'(sync_ok), 32'h0);
    checkOutput("async_fv", 32'(frame_valid), 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #2;
    send_slot(1'b1, 24'h000000, 20);
    applyStimulus(24'h123456, 24'hFEDCBA);
    checkOutput("fv_count_after_reset", 32'(fv_count), 32'd11);
    checkOutput("sync_after_reset_frame", 32'(sync_ok), 32'h0);
    pulse_clken(18'h048D1, 18'h3FB73);

    checkOutput("queue_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
